// File: rtl/nibble_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
package nibble_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned NIB_BITS = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << result) < value) result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/padd4_slice.sv
// Combinational 4-bit ripple adder built from four full-adder cells; exposes the carry into bit 3.
module padd4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        co = carry[4];
        c3 = carry[3];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a shared 4-bit slice,
// with valid/ready handshakes on the command and result sides.
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / NIB_BITS;
    localparam int unsigned CNT_W = (NIB > 1) ? clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    generate
        if ((WIDTH % NIB_BITS) != 0 || WIDTH < NIB_BITS) begin : gBadWidth
            $error("nibble_serial_adder_ctrl: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             carry;

    logic [3:0]       aNib;
    logic [3:0]       bNib;
    logic [3:0]       sNib;
    logic             sliceCo;
    logic             sliceC3;
    logic [WIDTH-1:0] sNibExt;

    // Nibble selection by shifting keeps the index math width-clean for any WIDTH.
    always_comb begin
        aNib       = 4'(opA >> {cnt, 2'b00});
        bNib       = 4'(opB >> {cnt, 2'b00});
        sNibExt    = '0;
        sNibExt[3:0] = sNib;
    end

    padd4_slice uSlice (
        .a  (aNib),
        .b  (bNib),
        .ci (carry),
        .s  (sNib),
        .co (sliceCo),
        .c3 (sliceC3)
    );

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            opA   <= '0;
            opB   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        opA   <= op_a;
                        opB   <= op_b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // sum was cleared on accept, so OR-ing each nibble into place is exact.
                    sum   <= sum | (sNibExt << {cnt, 2'b00});
                    carry <= sliceCo;
                    if (cnt == LAST_CNT) begin
                        cout  <= sliceCo;
                        ovf   <= sliceC3 ^ sliceCo;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16) with a result scoreboard.
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    exp_t sb[$];
    int   nChecks = 0;
    int   nPass = 0;
    int   nAccepts = 0;
    int   nResults = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && res_valid === 1'b1 && res_ready === 1'b1) begin
                nResults++;
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("cout", 32'(cout), 32'(e.c));
                    chk("ovf", 32'(ovf), 32'(e.o));
                end
            end
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        while (start_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("wait_start_ready", 32'd0, 32'd1);
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input int hold, input bit junk);
        int lat;
        int busyCnt;
        waitIdle();
        op_a = a; op_b = b; cin = ci; start_valid = 1'b1;
        sb.push_back('{s: es, c: ec, o: eo});
        nAccepts++;
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0; busyCnt = 0;
        while (res_valid !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busyCnt++;
            if (junk && lat == 1) begin
                start_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1;
            end else if (junk) begin
                start_valid = 1'b0;
            end
            @(posedge clk); #1; lat++;
        end
        start_valid = 1'b0;
        chk("latency", 32'(lat), 32'd4);
        chk("busy_cycles", 32'(busyCnt), 32'd4);
        for (int i = 0; i < hold; i++) begin
            chk("hold_sum", 32'(sum), 32'(es));
            chk("hold_cout_ovf", {30'd0, cout, ovf}, {30'd0, ec, eo});
            chk("hold_start_ready", 32'(start_ready), 32'd0);
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            op_a = 16'(i * 16'h1357); op_b = ~op_a; start_valid = ~start_valid;
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("idle_after_handshake", {30'd0, start_ready, res_valid}, 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_flags", {28'd0, start_ready, res_valid, busy, cout}, 32'b1000);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;

        runOp(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0);
        runOp(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        runOp(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        runOp(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
        runOp(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
        runOp(16'h0F0F, 16'h1111, 1'b0, 16'h2020, 1'b0, 1'b0, 3, 1'b0);
        runOp(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 1'b0);
        runOp(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0, 1'b1);

        // Abort an operation with reset after two nibble edges.
        waitIdle();
        op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_flags", {29'd0, start_ready, res_valid, busy}, 32'b100);
        chk("midreset_sum", 32'(sum), 32'd0);
        runOp(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("one_result_per_accept", 32'(nResults), 32'(nAccepts));
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by reusing one 4-bit ripple adder slice over WIDTH/4 clock cycles, least significant nibble first.
- Carry is held in a register between nibbles.
- Gives wide additions a small adder footprint; connects to requesters through valid/ready handshakes on the command side and the result side.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NIB, WIDTH/4, derived: number of nibble steps; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  requester presents an operation.
- start_ready  output  1  controller can accept; high only in IDLE.
- op_a  input  WIDTH  operand A, sampled on accept.
- op_b  input  WIDTH  operand B, sampled on accept.
- cin  input  1  carry-in, sampled on accept.
- res_valid  output  1  result available; high only in DONE.
- res_ready  input  1  consumer takes the result.
- sum  output  WIDTH  op_a + op_b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN.

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to IDLE; cnt, carry, sum, cout, ovf go to 0.
  - res_valid=0, busy=0; start_ready=1 from the next cycle.
  - Reset overrides every other input, including mid-RUN and DONE; any partial result is discarded.
- States:
  - IDLE: start_ready=1. Accept edge = start_valid&start_ready. On accept: latch op_a, op_b, cin into internal registers; carry<=cin; cnt<=0; sum<=0; go to RUN.
  - RUN: each edge adds nibble cnt of the latched operands plus carry through the slice. Writes sum[4*cnt+3:4*cnt] and carry<=slice carry-out; cnt<=cnt+1. On the edge where cnt==NIB-1: cout<=slice carry-out, ovf<=slice carry into bit 3 XOR slice carry-out, go to DONE.
  - DONE: res_valid=1; sum/cout/ovf held stable. Edge with res_ready=1 goes to IDLE; otherwise stay (unbounded backpressure).
- Latency:
  - res_valid rises exactly NIB edges after the accept edge (WIDTH=16: 4 edges).
  - Minimum issue interval is NIB+2 cycles: accept, NIB run edges, one DONE handshake edge, then IDLE. There is no accept directly from DONE.
- Input rules:
  - start_valid is ignored in RUN and DONE.
  - op_a/op_b/cin changes after accept have no effect.
  - res_ready is ignored outside DONE.
- Output stability:
  - sum/cout/ovf retain the last result in IDLE until the next accept clears sum.
  - They are only meaningful while res_valid=1.
- Counter: cnt is clog2(NIB) bits wide (minimum 1). It never wraps during an operation; it is cleared on accept.
- NIB=1: RUN lasts one edge.

Decomposition:
- Shared package nibble_adder_pkg:
  - state enum {IDLE, RUN, DONE}.
  - NIB_BITS constant (4).
  - clog2 helper for cnt width.
- Sub-module padd4_slice: purely combinational 4-bit ripple adder with inputs a[3:0], b[3:0], ci and outputs s[3:0], co, c3 (carry into bit 3). Built from four full-adder cells; one instance in the controller.
- Controller holds the FSM, cnt, operand registers, carry and result registers.

Test Plan (WIDTH=16):
- Basic: accept op_a=0x1234, op_b=0x4321, cin=0 -> res_valid high 4 edges after accept; sum=0x5555, cout=0, ovf=0; busy high for exactly 4 cycles.
- Full carry ripple: 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also 0x0000 + 0x0000 with cin=1 -> sum=0x0001, cout=0.
- Signed overflow: 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1. Also 0x8000 + 0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure/isolation:
  - Hold res_ready=0 for 3 cycles in DONE while toggling op_a, op_b, start_valid -> sum/cout/ovf unchanged, start_ready=0.
  - Raise res_ready -> IDLE the next cycle; second op 0x00F0+0x0010 -> 0x0100.
- Reset mid-operation: assert reset on the edge after nibble 1 of 0xAAAA+0x5555 -> next cycle state IDLE, start_ready=1, res_valid=0, sum=0, busy=0. A following op 0x0001+0x0001 -> 0x0002.
- Ignored start: pulse start_valid with new operands during RUN -> no effect on the in-flight result; exactly one res_valid per accept.
